// File: rtl/lpc_pkg.sv
// Shared constants and helpers for the precision-scalable LPC multiply-accumulate unit.
package lpc_pkg;

    // Element precision selected per beat.
    localparam logic [1:0] LPC_MODE_2B  = 2'b00;
    localparam logic [1:0] LPC_MODE_4B  = 2'b01;
    localparam logic [1:0] LPC_MODE_8B  = 2'b10;
    localparam logic [1:0] LPC_MODE_OFF = 2'b11;

    // Widest signed lane sum: (-128)*(-128) = 16384 needs 16 bits plus sign headroom.
    localparam int LANE_SUM_W = 17;

    // Full-precision width of the sum of all lane sums.
    function automatic int beat_sum_w(input int lanes);
        return LANE_SUM_W + $clog2(lanes);
    endfunction

endpackage

// File: rtl/lpc_lane_dot.sv
// One 8-bit lane: elementwise signed dot product of a and b at the precision set by mode.
module lpc_lane_dot
    import lpc_pkg::*;
(
    input  logic        [7:0]            a,
    input  logic        [7:0]            b,
    input  logic        [1:0]            mode,
    output logic signed [LANE_SUM_W-1:0] sum
);

    logic signed [LANE_SUM_W-1:0] p2 [4];
    logic signed [LANE_SUM_W-1:0] p4 [2];
    logic signed [LANE_SUM_W-1:0] p8;

    // Element products are formed at lane-sum width so no intermediate can overflow.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_p2
            assign p2[gi] = LANE_SUM_W'($signed(a[2*gi +: 2])) * LANE_SUM_W'($signed(b[2*gi +: 2]));
        end
        for (gi = 0; gi < 2; gi++) begin : g_p4
            assign p4[gi] = LANE_SUM_W'($signed(a[4*gi +: 4])) * LANE_SUM_W'($signed(b[4*gi +: 4]));
        end
    endgenerate

    assign p8 = LANE_SUM_W'($signed(a)) * LANE_SUM_W'($signed(b));

    // Select the reduction matching the element size; an idle lane contributes zero.
    always_comb begin
        sum = '0;
        case (mode)
            LPC_MODE_2B: sum = p2[0] + p2[1] + p2[2] + p2[3];
            LPC_MODE_4B: sum = p4[0] + p4[1];
            LPC_MODE_8B: sum = p8;
            default:     sum = '0;
        endcase
    end

endmodule

// File: rtl/lpc_mac_acc.sv
// Pipelined, precision-scalable signed multiply-accumulate over LANES 8-bit lanes.
// Stages: S0 input capture, S1 beat-sum register, S2 accumulate, then result register.
// Optional macro LPC_SAT_EN: saturating arithmetic plus a sat_flag output.
module lpc_mac_acc
    import lpc_pkg::*;
#(
    parameter int LANES = 4,
    parameter int ACC_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*LANES-1:0]      i_x,
    input  logic [8*LANES-1:0]      i_y,
    input  logic [1:0]              mode,
    input  logic                    in_valid,
    input  logic                    acc_clr,
    input  logic                    acc_last,
    output logic signed [ACC_W-1:0] mac_out,
    output logic                    out_valid
`ifdef LPC_SAT_EN
    ,
    output logic                    sat_flag
`endif
);

    localparam int BEAT_W = beat_sum_w(LANES);

    // S0 registers
    logic [8*LANES-1:0] s0_x_reg;
    logic [8*LANES-1:0] s0_y_reg;
    logic [1:0]         s0_mode_reg;
    logic               s0_clr_reg;
    logic               s0_last_reg;
    logic               s0_valid_reg;

    // S1 registers
    logic signed [ACC_W-1:0] s1_sum_reg;
    logic                    s1_clr_reg;
    logic                    s1_last_reg;
    logic                    s1_valid_reg;

    // S2 / output registers
    logic signed [ACC_W-1:0] acc_reg;
    logic signed [ACC_W-1:0] acc_next;
    logic                    prev_last_reg;
    logic                    s2_last_reg;
    logic signed [ACC_W-1:0] mac_out_reg;
    logic                    out_valid_reg;

    logic signed [LANE_SUM_W-1:0] lane_sum [LANES];
    logic signed [BEAT_W-1:0]     beat_sum;
    logic signed [ACC_W-1:0]      beat_conv;
    logic                         acc_start;
    logic signed [ACC_W-1:0]      acc_base;

`ifdef LPC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic               beat_ovf;
    logic               s1_sat_reg;
    logic               sat_acc_reg;
    logic               sat_next;
    logic               sat_flag_reg;
    logic               acc_ovf;
    logic signed [ACC_W:0] acc_wide;
`endif

    // S0: capture operands on valid beats; the valid bit tracks in_valid every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_reg <= 1'b0;
            s0_x_reg     <= '0;
            s0_y_reg     <= '0;
            s0_mode_reg  <= LPC_MODE_OFF;
            s0_clr_reg   <= 1'b0;
            s0_last_reg  <= 1'b0;
        end else begin
            s0_valid_reg <= in_valid;
            if (in_valid) begin
                s0_x_reg    <= i_x;
                s0_y_reg    <= i_y;
                s0_mode_reg <= mode;
                s0_clr_reg  <= acc_clr;
                s0_last_reg <= acc_last;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            lpc_lane_dot u_lane (
                .a    (s0_x_reg[8*gi +: 8]),
                .b    (s0_y_reg[8*gi +: 8]),
                .mode (s0_mode_reg),
                .sum  (lane_sum[gi])
            );
        end
    endgenerate

    // Reduce all lane sums at full precision.
    always_comb begin
        beat_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            beat_sum = beat_sum + BEAT_W'(lane_sum[k]);
        end
    end

`ifdef LPC_SAT_EN
    // Clamp the beat sum into ACC_W when it is wider; otherwise sign-extend.
    generate
        if (BEAT_W > ACC_W) begin : g_beat_narrow
            logic [BEAT_W-ACC_W:0] beat_top;
            assign beat_top  = beat_sum[BEAT_W-1:ACC_W-1];
            assign beat_ovf  = !((&beat_top) || !(|beat_top));
            assign beat_conv = beat_ovf ? (beat_sum[BEAT_W-1] ? ACC_MIN : ACC_MAX)
                                        : beat_sum[ACC_W-1:0];
        end else begin : g_beat_wide
            assign beat_ovf  = 1'b0;
            assign beat_conv = ACC_W'(beat_sum);
        end
    endgenerate
`else
    // Wrap-around conversion: sign-extend or drop upper bits.
    assign beat_conv = ACC_W'(beat_sum);
`endif

    // S1: register the converted beat sum with its framing flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_sum_reg   <= '0;
            s1_clr_reg   <= 1'b0;
            s1_last_reg  <= 1'b0;
`ifdef LPC_SAT_EN
            s1_sat_reg   <= 1'b0;
`endif
        end else begin
            s1_valid_reg <= s0_valid_reg;
            s1_sum_reg   <= beat_conv;
            s1_clr_reg   <= s0_clr_reg;
            s1_last_reg  <= s0_last_reg;
`ifdef LPC_SAT_EN
            s1_sat_reg   <= beat_ovf;
`endif
        end
    end

    // Accumulator next value: restart on clr or after a finished accumulation.
    always_comb begin
        acc_start = s1_clr_reg || prev_last_reg;
        acc_base  = acc_start ? '0 : acc_reg;
`ifdef LPC_SAT_EN
        acc_wide  = {acc_base[ACC_W-1], acc_base} + {s1_sum_reg[ACC_W-1], s1_sum_reg};
        acc_ovf   = acc_wide[ACC_W] != acc_wide[ACC_W-1];
        acc_next  = acc_ovf ? (acc_wide[ACC_W] ? ACC_MIN : ACC_MAX) : acc_wide[ACC_W-1:0];
        sat_next  = (!acc_start && sat_acc_reg) || s1_sat_reg || acc_ovf;
`else
        acc_next  = acc_base + s1_sum_reg;
`endif
    end

    // S2: update the accumulator on valid beats only; bubbles hold it.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg       <= '0;
            prev_last_reg <= 1'b1;
            s2_last_reg   <= 1'b0;
`ifdef LPC_SAT_EN
            sat_acc_reg   <= 1'b0;
`endif
        end else begin
            s2_last_reg <= s1_valid_reg && s1_last_reg;
            if (s1_valid_reg) begin
                acc_reg       <= acc_next;
                prev_last_reg <= s1_last_reg;
`ifdef LPC_SAT_EN
                sat_acc_reg   <= sat_next;
`endif
            end
        end
    end

    // Result register: publish the finished accumulation and pulse out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            mac_out_reg   <= '0;
            out_valid_reg <= 1'b0;
`ifdef LPC_SAT_EN
            sat_flag_reg  <= 1'b0;
`endif
        end else begin
            out_valid_reg <= s2_last_reg;
            if (s2_last_reg) begin
                mac_out_reg  <= acc_reg;
`ifdef LPC_SAT_EN
                sat_flag_reg <= sat_acc_reg;
`endif
            end
        end
    end

    assign mac_out   = mac_out_reg;
    assign out_valid = out_valid_reg;
`ifdef LPC_SAT_EN
    assign sat_flag  = sat_flag_reg;
`endif

endmodule

// File: tb/tb_lpc_mac_acc.sv
// Self-checking bench for lpc_mac_acc: a 32-bit and a 16-bit accumulator instance
// share stimulus; an arithmetic model predicts every output cycle.
module tb_lpc_mac_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_x, i_y;
    logic [1:0]  mode;
    logic        in_valid, acc_clr, acc_last;
    logic [31:0] mac_out32;
    logic        ov32;
    logic [15:0] mac_out16;
    logic        ov16;
`ifdef LPC_SAT_EN
    logic        sf32, sf16;
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    lpc_mac_acc #(.LANES(4), .ACC_W(32)) dut32 (
        .clk(clk), .rst(rst), .i_x(i_x), .i_y(i_y), .mode(mode),
        .in_valid(in_valid), .acc_clr(acc_clr), .acc_last(acc_last),
        .mac_out(mac_out32), .out_valid(ov32)
`ifdef LPC_SAT_EN
        , .sat_flag(sf32)
`endif
    );

    lpc_mac_acc #(.LANES(4), .ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .i_x(i_x), .i_y(i_y), .mode(mode),
        .in_valid(in_valid), .acc_clr(acc_clr), .acc_last(acc_last),
        .mac_out(mac_out16), .out_valid(ov16)
`ifdef LPC_SAT_EN
        , .sat_flag(sf16)
`endif
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic longint sx(input logic [31:0] v, input int w);
        longint u;
        u = longint'(v) & ((longint'(1) << w) - 1);
        if (u >= (longint'(1) << (w - 1))) u -= (longint'(1) << w);
        return u;
    endfunction

    function automatic longint model_beat(input logic [31:0] x, input logic [31:0] y, input logic [1:0] md);
        longint s;
        int ew;
        s = 0;
        case (md)
            2'b00:   ew = 2;
            2'b01:   ew = 4;
            2'b10:   ew = 8;
            default: return 0;
        endcase
        for (int l = 0; l < 4; l++)
            for (int e = 0; e < 8 / ew; e++)
                s += sx(x >> (8 * l + e * ew), ew) * sx(y >> (8 * l + e * ew), ew);
        return s;
    endfunction

    // Fit v into w signed bits: clamp when saturating, else wrap.
    function automatic longint fit(input longint v, input int w, output bit clamped);
        longint hi, lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        clamped = 1'b0;
        if (SAT) begin
            if (v > hi) begin clamped = 1'b1; return hi; end
            if (v < lo) begin clamped = 1'b1; return lo; end
            return v;
        end
        return sx(v[31:0], w) + ((w > 32) ? 0 : 0);
    endfunction

    typedef struct { int due; longint val; bit sat; } exp_t;
    exp_t   q0[$];
    exp_t   q1[$];
    longint m_acc [2];
    bit     m_sat [2];
    bit     m_prev_last;
    longint e_mac [2];
    bit     e_sat [2];

    // Model update at each rising edge from the inputs that edge samples.
    always @(posedge clk) begin
        longint beat, bc, a;
        bit     start, f1, f2;
        int     w;
        exp_t   ent;
        cyc = cyc + 1;
        if (rst) begin
            m_prev_last = 1'b1;
            q0.delete();
            q1.delete();
            for (int k = 0; k < 2; k++) begin
                m_acc[k] = 0; m_sat[k] = 0; e_mac[k] = 0; e_sat[k] = 0;
            end
        end else if (in_valid) begin
            beat  = model_beat(i_x, i_y, mode);
            start = acc_clr || m_prev_last;
            for (int k = 0; k < 2; k++) begin
                w  = (k == 0) ? 32 : 16;
                bc = fit(beat, w, f1);
                a  = start ? bc : m_acc[k] + bc;
                a  = fit(a, w, f2);
                m_sat[k] = (start ? 1'b0 : m_sat[k]) | f1 | f2;
                m_acc[k] = a;
                if (acc_last) begin
                    ent.due = cyc + 3; ent.val = a; ent.sat = m_sat[k];
                    if (k == 0) q0.push_back(ent); else q1.push_back(ent);
                end
            end
            m_prev_last = acc_last;
        end
    end

    // Compare both instances every cycle once the clock has started.
    always @(negedge clk) begin
        bit ev;
        if (cyc > 0) begin
            ev = (q0.size() > 0) && (q0[0].due == cyc);
            chk("out_valid32", longint'(ov32), longint'(ev));
            if (ev) begin e_mac[0] = q0[0].val; e_sat[0] = q0[0].sat; void'(q0.pop_front()); end
            chk("mac_out32", longint'($signed(mac_out32)), e_mac[0]);
            ev = (q1.size() > 0) && (q1[0].due == cyc);
            chk("out_valid16", longint'(ov16), longint'(ev));
            if (ev) begin e_mac[1] = q1[0].val; e_sat[1] = q1[0].sat; void'(q1.pop_front()); end
            chk("mac_out16", longint'($signed(mac_out16)), e_mac[1]);
`ifdef LPC_SAT_EN
            chk("sat_flag32", longint'(sf32), longint'(e_sat[0]));
            chk("sat_flag16", longint'(sf16), longint'(e_sat[1]));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic [1:0] md,
                         input logic clr, input logic last);
        @(negedge clk);
        i_x = {4{x}}; i_y = {4{y}}; mode = md;
        acc_clr = clr; acc_last = last; in_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            i_x = $urandom; i_y = $urandom; mode = 2'($urandom);
            acc_clr = 1'($urandom); acc_last = 1'($urandom);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; i_x = '0; i_y = '0; mode = 2'b11;
        acc_clr = 1'b0; acc_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_mac_out", longint'(mac_out32), 0);
        chk("reset_out_valid", longint'(ov32), 0);
        rst = 1'b0;
        idle(2);

        // 8-bit negative extremes
        drive(8'h80, 8'h80, 2'b10, 1'b1, 1'b1);
        idle(6);
        chk("lit_8b_extreme", longint'($signed(mac_out32)), 65536);

        // 4-bit mixed signs
        drive(8'h7F, 8'h97, 2'b01, 1'b1, 1'b1);
        idle(6);
        chk("lit_4b_mixed", longint'($signed(mac_out32)), -224);

        // 2-bit accumulation with bubbles
        drive(8'hFF, 8'hAA, 2'b00, 1'b1, 1'b0);
        idle(2);
        drive(8'hFF, 8'hAA, 2'b00, 1'b0, 1'b0);
        idle(3);
        drive(8'hFF, 8'hAA, 2'b00, 1'b0, 1'b1);
        idle(6);
        chk("lit_2b_accum", longint'($signed(mac_out32)), 96);

        // Mode off then mid-stream mode change
        drive(8'h55, 8'h33, 2'b11, 1'b1, 1'b0);
        drive(8'h02, 8'h02, 2'b10, 1'b0, 1'b1);
        idle(6);
        chk("lit_mode_change", longint'($signed(mac_out32)), 16);

        // Reset mid-accumulation
        drive(8'h01, 8'h01, 2'b10, 1'b1, 1'b0);
        drive(8'h01, 8'h01, 2'b10, 1'b0, 1'b0);
        @(negedge clk); in_valid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        drive(8'h01, 8'h01, 2'b10, 1'b0, 1'b1);
        idle(6);
        chk("lit_reset_mid", longint'($signed(mac_out32)), 4);

        // Clear mid-accumulation discards the partial sum
        drive(8'h03, 8'h05, 2'b10, 1'b1, 1'b0);
        drive(8'h02, 8'h07, 2'b10, 1'b1, 1'b1);
        idle(6);
        chk("lit_clr_mid", longint'($signed(mac_out32)), 56);

        // Narrow accumulator overflow
        drive(8'h80, 8'h80, 2'b10, 1'b1, 1'b1);
        idle(6);
`ifdef LPC_SAT_EN
        chk("lit_16b_sat", longint'($signed(mac_out16)), 32767);
        chk("lit_16b_sat_flag", longint'(sf16), 1);
`else
        chk("lit_16b_wrap", longint'($signed(mac_out16)), 0);
`endif
        chk("lit_32b_same_beat", longint'($signed(mac_out32)), 65536);

        // Back-to-back beats of mixed framing and modes
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            i_x = $urandom; i_y = $urandom; mode = 2'($urandom);
            acc_clr = ($urandom_range(0, 4) == 0);
            acc_last = ($urandom_range(0, 3) == 0);
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/lpc_mac_acc.md
Name: lpc_mac_acc

Overview:
- Parametrised, pipelined, precision-scalable signed multiply-accumulate unit; successor to the single-lane 8x8 LPC multiplier.
- LANES 8-bit operand lanes; each lane is split into 4x2-bit, 2x4-bit or 1x8-bit signed element pairs by mode.
- Element products from all lanes are reduced into one dot product per beat, then accumulated across beats with valid/clear/last framing.
- Sits in the PE array between the operand-broadcast registers and the output drain.

Parameters:
- LANES, 4, number of 8-bit operand lanes (1..16).
- ACC_W, 32, accumulator and output width in bits (>= 16).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- i_x  in  8*LANES  operand X; lane k = i_x[8k+7:8k].
- i_y  in  8*LANES  operand Y; same lane layout as i_x.
- mode  in  2  00: 2-bit elements; 01: 4-bit elements; 10: 8-bit elements; 11: off.
- in_valid  in  1  beat qualifier for i_x, i_y, mode, acc_clr and acc_last.
- acc_clr  in  1  this beat starts a new accumulation.
- acc_last  in  1  this beat ends the accumulation.
- mac_out  out  ACC_W  signed accumulated result.
- out_valid  out  1  one-cycle pulse; mac_out holds a new result.

Behaviour:
- Elements are two's-complement. Lane k pairs element j of X with element j of Y (elementwise, no cross terms).
  - 00: 4 products of 2b x 2b.
  - 01: 2 products of 4b x 4b (low nibble with low nibble, high with high).
  - 10: 1 product of 8b x 8b.
  - 11: the lane contributes 0.
- Lane sum is sign-extended. Beat sum = sum of all LANES lane sums, computed at full precision, then sign-extended or truncated to ACC_W.
- Pipeline, one beat per cycle, no backpressure:
  - S0: register the inputs when in_valid is high; the S0 valid bit follows in_valid.
  - S1: register the beat sum plus the clr/last flags.
  - S2: accumulator update.
- Accumulator update on an S1-valid beat:
  - acc = beat_sum if clr is set or the previous accepted beat was last; otherwise acc = acc + beat_sum.
  - Bubbles (valid low) hold acc unchanged.
- Latency: a beat carrying acc_last presented at edge t gives out_valid=1 and mac_out=final acc after edge t+3.
- mac_out holds its value until the next out_valid.
- acc_clr and acc_last may both be set on the same beat (single-beat result).
- mode is sampled per beat; changing mode inside an accumulation is legal, and each beat is computed in its own mode.
- acc_clr mid-accumulation discards the partial sum with no output.
- Overflow wraps two's-complement (see the optional feature).
- Reset values: mac_out=0, out_valid=0, acc=0, all stage valids=0, the "previous beat was last" flag=1.
- Reset mid-accumulation drops all in-flight beats. The first beat after reset starts fresh even without acc_clr.
- in_valid low: every other input is don't-care.

Optional Feature:
- Macro LPC_SAT_EN.
- Defined:
  - Beat-sum conversion to ACC_W saturates.
  - Each accumulate saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Adds output sat_flag (1 bit), registered alongside mac_out. It is set if any saturation occurred in the emitted accumulation and cleared at the start of the next accumulation.
- Undefined: wrap-around arithmetic, and no sat_flag port exists.

Decomposition:
- Package lpc_pkg:
  - Mode constants LPC_MODE_2B=2'b00, LPC_MODE_4B=2'b01, LPC_MODE_8B=2'b10, LPC_MODE_OFF=2'b11.
  - LANE_SUM_W=17 (widest signed lane sum, from 8-bit mode).
  - Function beat_sum_w(LANES) = LANE_SUM_W + $clog2(LANES).
- Sub-module lpc_lane_dot: combinational, one lane. Inputs a[7:0], b[7:0], mode; output signed lane sum [LANE_SUM_W-1:0]. Instantiated LANES times by generate.

Test Plan (LANES=4, ACC_W=32 unless noted):
- 8-bit, negative extremes: mode=10, every lane x=8'h80, y=8'h80, clr=1, last=1 → after 3 edges out_valid=1 for one cycle, mac_out=65536.
- 4-bit mixed signs: mode=01, every lane x=8'h7F, y=8'h97 (per lane (-1)(7)+(7)(-7)=-56), clr=last=1 → mac_out=-224 (32'hFFFFFF20).
- 2-bit accumulation with bubbles: mode=00, x=8'hFF, y=8'hAA (each product 2, beat=32), 3 beats with idle cycles between, clr on the 1st, last on the 3rd → out_valid only after the 3rd beat + 3 edges, mac_out=96.
- Mode off and mid-stream mode change: beat1 mode=11 with clr, beat2 mode=10 with x=y=8'h02 on all lanes and last → mac_out=16.
- Reset mid-accumulation: 2 beats of mode=10 x=y=8'h01 with clr, assert rst, then 1 beat with last but no clr → out_valid low during and after reset until that beat; mac_out=4, not 12.
- ACC_W=16, mode=10, every lane x=y=8'h80, clr=last=1 → LPC_SAT_EN defined: mac_out=32767, sat_flag=1. Not defined: mac_out=0 (wrap).
